// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: widens IN by MODE, queues the result in a
// 2-entry elastic buffer with valid/ready on both sides, counts deliveries.
module imm_ext_pipe #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned SHIFT     = 2,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [IN_WIDTH-1:0]  IN,
  input  logic [1:0]           MODE,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [OUT_WIDTH-1:0] OUT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [CNT_WIDTH-1:0] CNT
);

  logic signed [IN_WIDTH-1:0]  in_s;
  logic        [OUT_WIDTH-1:0] sext;
  logic        [OUT_WIDTH-1:0] ext;

  assign in_s = IN;

  // Casting a signed operand up to OUT_WIDTH replicates the sign bit, which
  // also stays legal when OUT_WIDTH == IN_WIDTH (zero-width padding).
  always_comb begin
    sext = OUT_WIDTH'(in_s);
    case (MODE)
      2'd0:    ext = sext;
      2'd1:    ext = OUT_WIDTH'(IN);
      2'd2:    ext = OUT_WIDTH'(IN) << (OUT_WIDTH - IN_WIDTH);
      default: ext = sext << SHIFT;
    endcase
  end

  logic [OUT_WIDTH-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [1:0]           count_next;
  logic                 in_ready_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 accept;
  logic                 deliver;

  assign accept  = IN_VALID && in_ready_q;
  assign deliver = (count != 2'd0) && OUT_READY;

  always_comb begin
    count_next = count;
    case ({accept, deliver})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // IN_READY is registered from the next occupancy, so OUT_READY never
  // reaches it combinationally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem[0]     <= '0;
      mem[1]     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= ext;
        wr_ptr      <= ~wr_ptr;
      end
      if (deliver) begin
        rd_ptr <= ~rd_ptr;
        cnt_q  <= cnt_q + 1'b1;
      end
      count      <= count_next;
      in_ready_q <= (count_next != 2'd2);
    end
  end

  assign OUT_VALID = (count != 2'd0);
  assign OUT       = (count != 2'd0) ? mem[rd_ptr] : '0;
  assign IN_READY  = in_ready_q;
  assign CNT       = cnt_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: stimulus pushes expected results, a
// negedge monitor pops and compares on every delivery.
module tb_imm_ext_pipe;

  logic        CLK;
  logic        RST_N;
  logic [15:0] IN;
  logic [1:0]  MODE;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] OUT;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  CNT;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_cnt = '0;

  imm_ext_pipe #(
    .IN_WIDTH (16),
    .OUT_WIDTH(32),
    .SHIFT    (2),
    .CNT_WIDTH(8)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IN       (IN),
    .MODE     (MODE),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .OUT      (OUT),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .CNT      (CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_sext(input logic [15:0] x);
    return {{16{x[15]}}, x};
  endfunction

  // Monitor: a delivery happens at the next posedge when OUT_VALID && OUT_READY.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        chk("cnt_before_delivery", 32'(CNT), 32'(exp_cnt));
        exp_cnt = exp_cnt + 8'd1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h, expected no delivery", OUT);
        end else begin
          e = exp_q.pop_front();
          chk("delivered_value", OUT, e);
        end
      end
    end
  end

  task automatic send(input logic [15:0] v, input logic [1:0] m, input logic [31:0] e,
                      output int unsigned waited);
    bit ok;
    ok = 0;
    waited = 0;
    IN = v;
    MODE = m;
    IN_VALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      waited++;
      if (IN_READY === 1'b1) begin
        exp_q.push_back(e);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, expected accept of %h", v);
    end
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    IN = '0;
    MODE = '0;
    repeat (2) @(posedge CLK);
    #1;
    exp_q.delete();
    exp_cnt = '0;
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd0);
    chk("rst_out", OUT, 32'd0);
    chk("rst_cnt", 32'(CNT), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("in_ready_before_first_edge", 32'(IN_READY), 32'd0);
    @(posedge CLK);
    #1;
    chk("in_ready_after_first_edge", 32'(IN_READY), 32'd1);
  endtask

  // Sends with an empty buffer and OUT_READY=1, then checks one-cycle latency.
  task automatic send_lat(input string name, input logic [15:0] v, input logic [1:0] m,
                          input logic [31:0] e);
    int unsigned w;
    send(v, m, e, w);
    chk({name, "_valid"}, 32'(OUT_VALID), 32'd1);
    chk(name, OUT, e);
    drain();
  endtask

  initial begin
    int unsigned w;

    RST_N = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    IN = '0;
    MODE = '0;

    // Sign-extend
    do_reset();
    OUT_READY = 1'b1;
    send_lat("sext_8001", 16'h8001, 2'd0, 32'hFFFF8001);
    send_lat("sext_7fff", 16'h7FFF, 2'd0, 32'h00007FFF);
    chk("sext_cnt", 32'(CNT), 32'd2);

    // Zero-extend and upper
    send_lat("zext_8001", 16'h8001, 2'd1, 32'h00008001);
    send_lat("upper_1234", 16'h1234, 2'd2, 32'h12340000);

    // Branch
    send_lat("br_ffff", 16'hFFFF, 2'd3, 32'hFFFFFFFC);
    send_lat("br_0001", 16'h0001, 2'd3, 32'h00000004);
    send_lat("br_8000", 16'h8000, 2'd3, 32'hFFFE0000);
    chk("mixed_cnt", 32'(CNT), 32'd7);

    // Backpressure
    do_reset();
    OUT_READY = 1'b0;
    send(16'h0001, 2'd1, 32'h00000001, w);
    send(16'h0002, 2'd1, 32'h00000002, w);
    chk("bp_in_ready_full", 32'(IN_READY), 32'd0);
    IN = 16'h0003;
    MODE = 2'd1;
    IN_VALID = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("bp_in_ready_held", 32'(IN_READY), 32'd0);
      chk("bp_out_valid", 32'(OUT_VALID), 32'd1);
      chk("bp_out_stable", OUT, 32'h00000001);
    end
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    send(16'h0003, 2'd1, 32'h00000003, w);
    drain();
    chk("bp_cnt", 32'(CNT), 32'd3);

    // Reset mid-operation
    do_reset();
    OUT_READY = 1'b1;
    send(16'h0011, 2'd1, 32'h00000011, w);
    drain();
    chk("mid_pre_cnt", 32'(CNT), 32'd1);
    OUT_READY = 1'b0;
    send(16'h0022, 2'd1, 32'h00000022, w);
    send(16'h0033, 2'd1, 32'h00000033, w);
    chk("mid_full_in_ready", 32'(IN_READY), 32'd0);
    #1;
    RST_N = 1'b0;
    #1;
    exp_q.delete();
    exp_cnt = '0;
    chk("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("mid_rst_out", OUT, 32'd0);
    chk("mid_rst_cnt", 32'(CNT), 32'd0);
    chk("mid_rst_in_ready", 32'(IN_READY), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    send_lat("mid_first_after_rst", 16'h00AA, 2'd1, 32'h000000AA);
    chk("mid_post_cnt", 32'(CNT), 32'd1);

    // Exhaustive streaming
    do_reset();
    OUT_READY = 1'b1;
    for (int unsigned i = 0; i < 65536; i++) begin
      send(16'(i), 2'd0, ref_sext(16'(i)), w);
      chk("stream_accept_wait", 32'(w), 32'd1);
      chk("stream_out_valid", 32'(OUT_VALID), 32'd1);
    end
    drain();
    chk("stream_cnt_wrapped", 32'(CNT), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
